bsg_tick_alarm: RTL and testbench
=================================

# bsg_tick_alarm

Programmable tick-driven alarm that sits directly downstream of the overflow counter. It consumes the counter's single-cycle overflow pulse as its time base (one tick per counter wrap), counts a software-programmed number of ticks, and raises an alarm event toward a consumer through a valid/yumi handshake. It supports one-shot and periodic modes, kick (restart) and disarm, and it reports alarms that were lost because the previous one was not yet consumed.

## Interface
- width_p, 16, width of the tick count and the remaining-ticks counter
- miss_width_p, 4, width of the saturating missed-alarm counter
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- tick_i  in  1  time-base pulse; connects to the upstream counter's overflow_o
- arm_v_i  in  1  arm request valid
- arm_ticks_i  in  width_p  alarm period in ticks
- arm_periodic_i  in  1  1 = periodic, 0 = one-shot
- arm_ready_o  out  1  arm request accepted this cycle when high with arm_v_i
- kick_i  in  1  reload the remaining count from the period (ARMED only)
- disarm_i  in  1  abort the alarm and return to IDLE
- alarm_v_o  out  1  alarm pending
- alarm_yumi_i  in  1  consumer takes the alarm; legal only when alarm_v_o = 1
- remaining_o  out  width_p  ticks left before the next fire
- missed_o  out  miss_width_p  alarms lost while one was pending; saturates
- state_o  out  2  00 IDLE, 01 ARMED, 10 FIRED

## Operation
- Registers: state_r, remaining_r, period_r, periodic_r, pending_r (drives alarm_v_o), missed_r.
- arm_ready_o = (state_r == IDLE). This is combinational from state only.
- IDLE: an arm handshake loads period_r and remaining_r from arm_ticks_i, captures periodic_r, clears missed_r, and moves to ARMED. An arm_ticks_i value of 0 is loaded as 1.
- ARMED with tick_i:
  - If remaining_r > 1, decrement remaining_r.
  - If remaining_r == 1, fire. A fire sets pending_r.
  - Periodic fire: reload remaining_r from period_r and stay in ARMED.
  - One-shot fire: set remaining_r to 0 and go to FIRED.
- Fire while pending_r = 1 and no yumi in the same cycle: missed_r increments and saturates at all-ones. pending_r stays 1.
- Fire in the same cycle as yumi: the old alarm is consumed and the new one is set. pending_r stays 1 and missed_r does not change.
- kick_i in ARMED reloads remaining_r from period_r. If a kick and a fire-eligible tick arrive together, the kick wins and there is no fire.
- kick_i is ignored in IDLE and FIRED.
- FIRED: alarm_yumi_i clears pending_r and moves to IDLE.
- disarm_i in ARMED or FIRED:
  - Moves to IDLE and clears remaining_r and pending_r.
  - Has highest priority: it overrides tick, kick and yumi.
  - Does not clear missed_r.
- disarm_i in IDLE has no effect.
- alarm_yumi_i without pending_r is ignored.
- Invariant: in IDLE, pending_r is always 0.
- Priority order per cycle: reset > disarm > arm handshake > kick > tick > yumi. yumi and a fire combine as described above.

## Timing
- Reset asserts asynchronously, at any time including mid-count. Reset values:
  - state IDLE, remaining_o 0, alarm_v_o 0, missed_o 0, period 0, one-shot mode.
  - arm_ready_o = 1.
- Reset deassertion is synchronous to clk_i.
- Arm handshake at edge n: state_o = ARMED and remaining_o = N from cycle n+1. Ticks sampled from edge n+1 onward are counted; a tick in the handshake cycle is ignored.
- Alarm latency: the fire tick sampled at edge n gives alarm_v_o = 1 from cycle n+1.
- An arm of N fires on the N-th counted tick. In periodic mode it fires every N ticks.
- yumi at edge n: alarm_v_o = 0 at n+1 unless a new fire occurred at n. In one-shot mode, arm_ready_o = 1 at n+1.
- All outputs are registered except arm_ready_o, which is combinational from state only.

## Test plan
- **Reset mid-count:** arm 10 one-shot, 4 ticks, pull reset_n_i low between edges. Required: state_o, remaining_o, alarm_v_o and missed_o read 0 immediately, before the next clock edge; arm_ready_o = 1.
- **One-shot:** arm 3, issue 3 ticks spaced 5 cycles apart. Required: remaining_o goes 3→2→1→0, alarm_v_o rises one cycle after the 3rd tick, state_o = FIRED. A yumi 2 cycles later gives state_o = IDLE and alarm_v_o = 0.
- **Zero / back-to-back:** arm 0, tick on consecutive cycles. Required: it fires on the first counted tick (loaded as 1). A tick in the arm-handshake cycle is not counted.
- **Periodic with misses:** arm 2 periodic, 40 ticks, never yumi. Required: 20 fires, alarm_v_o held at 1, missed_o = 15 (saturated). Re-arm after a disarm gives missed_o = 0.
- **Periodic with yumi on the fire cycle:** arm 1 periodic, tick every cycle, yumi every cycle. Required: alarm_v_o stays 1 and missed_o stays 0.
- **Kick / disarm races:** arm 5, 4 ticks, then kick together with tick. Required: no fire and remaining_o = 5. Next, disarm together with a fire tick. Required: IDLE, alarm_v_o = 0, remaining_o = 0.

Source files
------------

// File: rtl/bsg_tick_alarm_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bsg_tick_alarm_if : control/alarm bundle between bsg_tick_alarm and its      |
// | arming agent / alarm consumer.                          Revision: 1.0        |
// +----------------------------------------------------------------------------+
interface bsg_tick_alarm_if #(
    parameter int width_p      = 16,
    parameter int miss_width_p = 4
);
    logic                    tick_i;
    logic                    arm_v_i;
    logic [width_p-1:0]      arm_ticks_i;
    logic                    arm_periodic_i;
    logic                    arm_ready_o;
    logic                    kick_i;
    logic                    disarm_i;
    logic                    alarm_v_o;
    logic                    alarm_yumi_i;
    logic [width_p-1:0]      remaining_o;
    logic [miss_width_p-1:0] missed_o;
    logic [1:0]              state_o;

    // The alarm block itself.
    modport slave (
        input  tick_i, arm_v_i, arm_ticks_i, arm_periodic_i, kick_i, disarm_i,
               alarm_yumi_i,
        output arm_ready_o, alarm_v_o, remaining_o, missed_o, state_o
    );

    // The software/agent side that arms the alarm and consumes it.
    modport master (
        output tick_i, arm_v_i, arm_ticks_i, arm_periodic_i, kick_i, disarm_i,
               alarm_yumi_i,
        input  arm_ready_o, alarm_v_o, remaining_o, missed_o, state_o
    );
endinterface
`default_nettype wire

// File: rtl/bsg_tick_alarm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bsg_tick_alarm : counts overflow ticks to a programmed period and raises a  |
// | valid/yumi alarm, one-shot or periodic, with a saturating miss count.        |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module bsg_tick_alarm #(
    parameter int width_p      = 16,
    parameter int miss_width_p = 4
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    bsg_tick_alarm_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARMED = 2'b01,
        FIRED = 2'b10
    } state_e;

    state_e                  state_r;
    logic [width_p-1:0]      remaining_r;
    logic [width_p-1:0]      period_r;
    logic                    periodic_r;
    logic                    pending_r;
    logic [miss_width_p-1:0] missed_r;

    logic                    yumi_take;
    logic [width_p-1:0]      arm_load;

    assign yumi_take = bus.alarm_yumi_i & pending_r;
    // A zero period would never fire; treat it as the shortest legal period.
    assign arm_load  = (bus.arm_ticks_i == '0) ? width_p'(1) : bus.arm_ticks_i;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r     <= IDLE;
            remaining_r <= '0;
            period_r    <= '0;
            periodic_r  <= 1'b0;
            pending_r   <= 1'b0;
            missed_r    <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.arm_v_i) begin
                        period_r    <= arm_load;
                        remaining_r <= arm_load;
                        periodic_r  <= bus.arm_periodic_i;
                        missed_r    <= '0;
                        state_r     <= ARMED;
                    end
                end
                ARMED: begin
                    if (bus.disarm_i) begin
                        state_r     <= IDLE;
                        remaining_r <= '0;
                        pending_r   <= 1'b0;
                    end else begin
                        if (yumi_take)
                            pending_r <= 1'b0;
                        if (bus.kick_i) begin
                            remaining_r <= period_r;
                        end else if (bus.tick_i) begin
                            if (remaining_r > width_p'(1)) begin
                                remaining_r <= remaining_r - width_p'(1);
                            end else begin
                                // Fire: a same-cycle yumi swaps old alarm for new.
                                pending_r <= 1'b1;
                                if (pending_r && !bus.alarm_yumi_i && (missed_r != '1))
                                    missed_r <= missed_r + miss_width_p'(1);
                                if (periodic_r) begin
                                    remaining_r <= period_r;
                                end else begin
                                    remaining_r <= '0;
                                    state_r     <= FIRED;
                                end
                            end
                        end
                    end
                end
                FIRED: begin
                    if (bus.disarm_i) begin
                        state_r     <= IDLE;
                        remaining_r <= '0;
                        pending_r   <= 1'b0;
                    end else if (yumi_take) begin
                        pending_r <= 1'b0;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    remaining_r <= '0;
                    pending_r   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.arm_ready_o = (state_r == IDLE);
    assign bus.alarm_v_o   = pending_r;
    assign bus.remaining_o = remaining_r;
    assign bus.missed_o    = missed_r;
    assign bus.state_o     = state_r;

endmodule
`default_nettype wire

// File: tb/tb_bsg_tick_alarm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_bsg_tick_alarm : directed self-checking bench for bsg_tick_alarm.        |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module tb_bsg_tick_alarm;

    localparam int c_width      = 16;
    localparam int c_miss_width = 4;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_err;

    bsg_tick_alarm_if #(.width_p(c_width), .miss_width_p(c_miss_width)) bus ();

    bsg_tick_alarm #(.width_p(c_width), .miss_width_p(c_miss_width)) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input logic [c_width-1:0] ticks, input logic periodic);
        bus.arm_v_i        = 1'b1;
        bus.arm_ticks_i    = ticks;
        bus.arm_periodic_i = periodic;
        step();
        bus.arm_v_i        = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bus.tick_i = 1'b1;
            step();
            bus.tick_i = 1'b0;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset_n            = 1'b0;
        bus.tick_i         = 1'b0;
        bus.arm_v_i        = 1'b0;
        bus.arm_ticks_i    = '0;
        bus.arm_periodic_i = 1'b0;
        bus.kick_i         = 1'b0;
        bus.disarm_i       = 1'b0;
        bus.alarm_yumi_i   = 1'b0;

        #3;
        check("rst_state", bus.state_o, 0);
        check("rst_rem",   bus.remaining_o, 0);
        check("rst_alarm", bus.alarm_v_o, 0);
        check("rst_missed", bus.missed_o, 0);
        check("rst_ready", bus.arm_ready_o, 1);
        step();
        step();
        reset_n = 1'b1;

        // Reset mid-count
        arm(16'd10, 1'b0);
        check("arm10_state", bus.state_o, 1);
        check("arm10_rem",   bus.remaining_o, 10);
        check("arm10_ready", bus.arm_ready_o, 0);
        ticks(4);
        check("arm10_rem4", bus.remaining_o, 6);
        #3 reset_n = 1'b0;
        #1;
        check("async_state", bus.state_o, 0);
        check("async_rem",   bus.remaining_o, 0);
        check("async_alarm", bus.alarm_v_o, 0);
        check("async_missed", bus.missed_o, 0);
        check("async_ready", bus.arm_ready_o, 1);
        reset_n = 1'b1;
        step();

        // One-shot of 3, ticks spaced 5 cycles
        arm(16'd3, 1'b0);
        check("os_rem0", bus.remaining_o, 3);
        for (int i = 1; i <= 3; i++) begin
            ticks(1);
            check("os_rem", bus.remaining_o, 3 - i);
            check("os_alarm", bus.alarm_v_o, (i == 3) ? 1 : 0);
            if (i < 3) repeat (4) step();
        end
        check("os_fired", bus.state_o, 2);
        step();
        check("os_hold", bus.alarm_v_o, 1);
        bus.alarm_yumi_i = 1'b1;
        step();
        bus.alarm_yumi_i = 1'b0;
        check("os_yumi_state", bus.state_o, 0);
        check("os_yumi_alarm", bus.alarm_v_o, 0);
        check("os_yumi_ready", bus.arm_ready_o, 1);

        // Zero period, tick during handshake is ignored
        bus.tick_i = 1'b1;
        arm(16'd0, 1'b0);
        check("z_rem", bus.remaining_o, 1);
        check("z_alarm0", bus.alarm_v_o, 0);
        step();
        bus.tick_i = 1'b0;
        check("z_alarm1", bus.alarm_v_o, 1);
        check("z_state", bus.state_o, 2);
        check("z_rem0", bus.remaining_o, 0);
        bus.alarm_yumi_i = 1'b1;
        step();
        bus.alarm_yumi_i = 1'b0;
        check("z_idle", bus.state_o, 0);

        // Periodic 2, never consumed: 20 fires, 19 misses saturating at 15
        arm(16'd2, 1'b1);
        ticks(2);
        check("pm_first", bus.alarm_v_o, 1);
        check("pm_miss0", bus.missed_o, 0);
        ticks(2);
        check("pm_miss1", bus.missed_o, 1);
        ticks(36);
        check("pm_alarm", bus.alarm_v_o, 1);
        check("pm_missed", bus.missed_o, 15);
        check("pm_state", bus.state_o, 1);
        check("pm_rem", bus.remaining_o, 2);
        bus.disarm_i = 1'b1;
        step();
        bus.disarm_i = 1'b0;
        check("pm_dis_state", bus.state_o, 0);
        check("pm_dis_alarm", bus.alarm_v_o, 0);
        check("pm_dis_missed", bus.missed_o, 15);
        arm(16'd2, 1'b1);
        check("pm_rearm_missed", bus.missed_o, 0);
        bus.disarm_i = 1'b1;
        step();
        bus.disarm_i = 1'b0;

        // Periodic 1 with yumi on every fire cycle
        arm(16'd1, 1'b1);
        bus.tick_i = 1'b1;
        step();
        check("py_first", bus.alarm_v_o, 1);
        for (int i = 0; i < 10; i++) begin
            bus.alarm_yumi_i = bus.alarm_v_o;
            step();
        end
        bus.tick_i = 1'b0;
        check("py_alarm", bus.alarm_v_o, 1);
        check("py_missed", bus.missed_o, 0);
        check("py_rem", bus.remaining_o, 1);
        bus.alarm_yumi_i = 1'b1;
        step();
        bus.alarm_yumi_i = 1'b0;
        check("py_drain", bus.alarm_v_o, 0);
        bus.disarm_i = 1'b1;
        step();
        bus.disarm_i = 1'b0;

        // Kick beats a fire tick; disarm beats a fire tick
        arm(16'd5, 1'b0);
        ticks(4);
        check("k_rem1", bus.remaining_o, 1);
        bus.kick_i = 1'b1;
        bus.tick_i = 1'b1;
        step();
        bus.kick_i = 1'b0;
        bus.tick_i = 1'b0;
        check("k_rem", bus.remaining_o, 5);
        check("k_alarm", bus.alarm_v_o, 0);
        check("k_state", bus.state_o, 1);
        ticks(4);
        bus.disarm_i = 1'b1;
        bus.tick_i   = 1'b1;
        step();
        bus.disarm_i = 1'b0;
        bus.tick_i   = 1'b0;
        check("d_state", bus.state_o, 0);
        check("d_alarm", bus.alarm_v_o, 0);
        check("d_rem", bus.remaining_o, 0);
        bus.kick_i = 1'b1;
        step();
        bus.kick_i = 1'b0;
        check("k_idle_state", bus.state_o, 0);
        check("k_idle_rem", bus.remaining_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
